// File: rtl/ttl_pseudo_clk_gen.sv
// ttl_pseudo_clk_gen: fractional-rate pseudo-clock with edge strobes and a single-edge ripple divider
module ttl_pseudo_clk_gen #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned NUM   = 1,
  parameter int unsigned DEN   = 3,
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  output logic             pclk,
  output logic             pclk_rise,
  output logic             pclk_fall,
  output logic             tick,
  output logic [DIV_W-1:0] div_q
);
  logic [ACC_W-1:0] r_acc;
  logic             r_pclk, r_rise, r_fall, r_tick;
  logic [DIV_W-1:0] r_div;
  logic [ACC_W:0]   w_sum, w_nxt;
  logic             w_ovf;
  assign w_sum = {1'b0, r_acc} + (ACC_W+1)'(NUM);
  assign w_ovf = w_sum >= (ACC_W+1)'(DEN);
  assign w_nxt = w_ovf ? w_sum - (ACC_W+1)'(DEN) : w_sum;
  // every stage toggling on its predecessor's 1->0 edge is a binary increment with full carry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_acc  <= '0;
      r_pclk <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_tick <= 1'b0;
      r_div  <= '0;
    end else if (sync) begin
      r_acc  <= '0;
      r_pclk <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_tick <= 1'b0;
      r_div  <= '0;
    end else if (en) begin
      r_acc  <= w_nxt[ACC_W-1:0];
      r_pclk <= r_pclk ^ w_ovf;
      r_rise <= w_ovf & ~r_pclk;
      r_fall <= w_ovf & r_pclk;
      r_tick <= w_ovf;
      r_div  <= r_div + DIV_W'(w_ovf & r_pclk);
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_tick <= 1'b0;
    end
  assign pclk      = r_pclk;
  assign pclk_rise = r_rise;
  assign pclk_fall = r_fall;
  assign tick      = r_tick;
  assign div_q     = r_div;
endmodule

// File: tb/tb_ttl_pseudo_clk_gen.sv
// tb_ttl_pseudo_clk_gen: three rate configurations checked against a closed-form overflow-count model
module tb_ttl_pseudo_clk_gen;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, sync = 1'b0;
  logic [2:0] pc, pr, pf, tk;
  logic [3:0] dq [3];
  int checks = 0, errors = 0;
  int nums [3] = '{1, 2, 3};
  int dens [3] = '{3, 5, 3};
  longint n [3] = '{0, 0, 0};
  typedef struct {int id; logic [7:0] v;} exp_t;
  exp_t q [$];
  always #5 clk = ~clk;
  ttl_pseudo_clk_gen #(.NUM(1), .DEN(3)) dut_a (.clk(clk), .rst_n(rst_n), .en(en), .sync(sync),
    .pclk(pc[0]), .pclk_rise(pr[0]), .pclk_fall(pf[0]), .tick(tk[0]), .div_q(dq[0]));
  ttl_pseudo_clk_gen #(.NUM(2), .DEN(5)) dut_b (.clk(clk), .rst_n(rst_n), .en(en), .sync(sync),
    .pclk(pc[1]), .pclk_rise(pr[1]), .pclk_fall(pf[1]), .tick(tk[1]), .div_q(dq[1]));
  ttl_pseudo_clk_gen #(.NUM(3), .DEN(3)) dut_c (.clk(clk), .rst_n(rst_n), .en(en), .sync(sync),
    .pclk(pc[2]), .pclk_rise(pr[2]), .pclk_fall(pf[2]), .tick(tk[2]), .div_q(dq[2]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] ov(input int i);
    return {pc[i], pr[i], pf[i], tk[i], dq[i]};
  endfunction
  // overflows after m enabled cycles = floor(m*NUM/DEN); pclk is its parity, falls are half of it
  function automatic logic [7:0] expv(input int i, input longint m, input bit adv);
    longint c = m * nums[i] / dens[i];
    longint cp = adv ? (m - 1) * nums[i] / dens[i] : c;
    logic t = (c != cp);
    return {c[0], t & c[0], t & ~c[0], t, 4'((c / 2) % 16)};
  endfunction
  task automatic step(input bit e, input bit s);
    en = e;
    sync = s;
    for (int i = 0; i < 3; i++) begin
      if (s) n[i] = 0;
      else if (e) n[i]++;
      q.push_back('{i, s ? 8'h00 : expv(i, n[i], e)});
    end
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      exp_t x = q.pop_front();
      chk($sformatf("cyc_dut%0d", x.id), 32'(ov(x.id)), 32'(x.v));
    end
  endtask
  task automatic first_tick_after_restart(input string tag);
    int k = 0;
    do begin step(1, 0); k++; end while (!tk[0] && k < 10);
    chk(tag, k, 3);
  endtask
  initial begin
    int k, hi, ft, ff, r1, r2, last, sp_idx, nt, nr, nf, prev, wraps;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("reset_dut%0d", i), 32'(ov(i)), 0);
    @(negedge clk) rst_n = 1'b1;
    ft = 0; ff = 0; r1 = 0; r2 = 0;
    for (int e = 1; e <= 12; e++) begin
      step(1, 0);
      if (tk[0] && ft == 0) ft = e;
      if (pf[0] && ff == 0) ff = e;
      if (pr[0]) begin if (r1 == 0) r1 = e; else if (r2 == 0) r2 = e; end
    end
    chk("first_tick", ft, 3);
    chk("first_rise", r1, 3);
    chk("first_fall", ff, 6);
    chk("pclk_period", r2 - r1, 6);
    k = 0;
    do begin step(1, 0); k++; end while (!pr[0] && k < 10);
    chk("hold_rise_seen", pr[0], 1);
    hi = 1;
    step(1, 0); hi += pc[0];
    repeat (4) begin step(0, 0); hi += pc[0]; end
    k = 0;
    while (!pf[0] && k < 10) begin step(1, 0); hi += pc[0]; k++; end
    chk("hold_high_len", hi, 7);
    k = 0;
    while (!((n[0] / 3) == 11 && ((n[0] + 1) / 3) == 12) && k < 200) begin step(1, 0); k++; end
    chk("pre_sync_pclk", pc[0], 1);
    chk("pre_sync_div", dq[0], 5);
    step(1, 1);
    chk("sync_out", 32'(ov(0)), 0);
    first_tick_after_restart("sync_first_tick");
    step(1, 1);
    nt = 0; nr = 0; nf = 0; last = 0; sp_idx = 0;
    for (int e = 1; e <= 50; e++) begin
      step(1, 0);
      nr += pr[1];
      nf += pf[1];
      if (tk[1]) begin
        nt++;
        if (last != 0) begin
          chk($sformatf("spacing%0d", sp_idx), e - last, (sp_idx % 2 == 0) ? 2 : 3);
          sp_idx++;
        end
        last = e;
      end
    end
    chk("frac_ticks", nt, 20);
    chk("frac_rises", nr, 10);
    chk("frac_falls", nf, 10);
    chk("frac_acc", 32'(dut_b.r_acc), 0);
    step(1, 1);
    wraps = 0;
    for (int e = 1; e <= 34; e++) begin
      prev = int'(dq[2]);
      step(1, 0);
      if (prev == 7 && pf[2]) chk("carry_7_8", dq[2], 8);
      if (prev == 15 && pf[2]) begin chk("wrap_15_0", dq[2], 0); wraps++; end
    end
    chk("wrap_count", wraps, 1);
    step(1, 1);
    repeat (21) step(1, 0);
    chk("pre_rst_pclk", pc[2], 1);
    chk("pre_rst_div", dq[2], 10);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("async_rst_dut%0d", i), 32'(ov(i)), 0);
      n[i] = 0;
    end
    @(negedge clk) rst_n = 1'b1;
    first_tick_after_restart("rst_first_tick");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ttl_pseudo_clk_gen.md
# ttl_pseudo_clk_gen

Pseudo-clock source for the synchronous TTL emulation layer. It derives slow board-clock waveforms (level signal plus one-cycle rise/fall strobes) from the single master clock using a fractional phase accumulator. It feeds a synchronous ripple-divider chain that emulates a 74LS393-style asynchronous counter. Outputs drive the clock-enable inputs of the edge-detecting pseudo-async flip-flops and counters, so every downstream device sees clean, glitch-free level transitions on master-clock boundaries.

## Interface

Parameters:
- ACC_W, 16, phase accumulator width.
- NUM, 1, accumulator increment per enabled cycle; 1 ≤ NUM ≤ DEN.
- DEN, 3, accumulator modulus; DEN < 2^ACC_W.
- DIV_W, 4, number of ripple-divider stages.

Ports:
- clk  in  1  master clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low; clears all state immediately, release is synchronous to clk.
- en  in  1  run enable; when low, all state holds.
- sync  in  1  synchronous phase restart; priority over en.
- pclk  out  1  pseudo-clock level; frequency = f_clk·NUM/(2·DEN).
- pclk_rise  out  1  one-cycle strobe, high in the cycle pclk first reads 1.
- pclk_fall  out  1  one-cycle strobe, high in the cycle pclk first reads 0.
- tick  out  1  one-cycle strobe on every accumulator overflow (either pclk edge).
- div_q  out  DIV_W  ripple-divider outputs; div_q[0] = pclk/2, div_q[k] = div_q[k-1]/2.

## Operation

- Accumulator: sum = acc + NUM, computed ACC_W+1 bits wide. If sum ≥ DEN, then acc ← sum − DEN and an overflow occurs. Otherwise acc ← sum.
- On overflow: pclk ← ~pclk. tick ← 1. pclk_rise ← ~pclk (old value). pclk_fall ← pclk (old value).
- Without overflow: tick, pclk_rise and pclk_fall ← 0. All three are registered, never combinational.
- Ripple divider, resolved entirely in one clk edge:
  - div_q[0] toggles on the edge where pclk goes 1→0.
  - div_q[k] toggles on the same edge where div_q[k-1] goes 1→0.
  - A full carry chain propagates in that single cycle, so there are no intermediate states.
- Divider wrap: after 2^DIV_W pclk falling edges, div_q returns to 0.
- en low: acc, pclk and div_q hold. Strobes are forced to 0 on the next edge.
- sync high, regardless of en: acc ← 0, pclk ← 0, div_q ← 0, all strobes ← 0. A sync cycle that would have overflowed produces no strobe.
- Reset (rst_n low), asynchronous: acc = 0, pclk = 0, div_q = 0, tick = 0, pclk_rise = 0, pclk_fall = 0. Reset asserted mid-operation clears outputs without waiting for clk.
- NUM = DEN: overflow on every enabled cycle; pclk toggles every clk.

## Timing

- From reset release or sync: with en held high, the first overflow is registered on enabled edge number ceil(DEN/NUM). Example: NUM=1, DEN=3 gives the first tick after the 3rd edge.
- pclk, its strobe and any div_q change are all visible after the same clk edge. No extra pipeline stage.
- Strobe width: exactly 1 clk. For NUM=DEN, tick stays high continuously and rise/fall alternate every cycle.
- Long-run average: over DEN·k enabled cycles, exactly NUM·k overflows, with no drift.
- en deasserted for N cycles stretches the current pclk phase by exactly N cycles.

## Test plan

- Reset values: hold rst_n low, then release with en=1, NUM=1, DEN=3.
  - All outputs read 0.
  - First tick and pclk_rise appear after edge 3.
  - pclk_fall appears after edge 6.
  - pclk period is 6 clk.
- Fractional rate: NUM=2, DEN=5, en=1 for 50 cycles.
  - Exactly 20 ticks, 10 rises, 10 falls.
  - Tick spacing alternates 2,3 cycles.
  - Final acc = 0.
- Enable hold: NUM=1, DEN=3, drop en for 4 cycles midway through a pclk-high phase.
  - pclk and div_q hold; strobes stay 0.
  - The high phase lasts 7 clk instead of 3.
- Sync restart: assert sync for 1 cycle on a cycle where overflow would occur, with pclk=1 and div_q=5.
  - No strobe is emitted.
  - All outputs read 0.
  - First tick arrives ceil(DEN/NUM) edges after sync release.
- Divider wrap: DIV_W=4, NUM=DEN.
  - div_q counts 0..15 and wraps to 0 on the 16th pclk fall.
  - At 7→8 and 15→0, all carried bits change on one clk edge.
- Async reset mid-run: assert rst_n low between clk edges while pclk=1 and div_q=0xA.
  - Outputs go to 0 before the next clk edge.
  - After release, the sequence restarts as in scenario 1.
